cpu_control_fsm: RTL and testbench
==================================

// Module: cpu_control_fsm
// PURPOSE
//  Multi-cycle control FSM for the 16-bit CPU, parametrised in instruction, address and register-file widths.
//  Sequences fetch/decode/execute and drives PC, IR-load, data-memory, register-file and ALU controls each cycle.
//  Adds branch/jump, sticky halt and a retired-instruction counter.
//  Sits between instruction memory/IR and the datapath (PC, data memory, register file, ALU).
// PARAMETERS
//  IR_W       16  instruction width; opcode = IR[IR_W-1 -: 4]
//  D_ADDR_W    8  data-memory address width; also the branch-target width
//  RF_ADDR_W   4  register-file address width
//  ALU_S_W     4  ALU function-select width
//  CNT_W      16  retired-instruction counter width
// PORTS
//  Clock      in   1          system clock, rising edge
//  Reset      in   1          asynchronous, active-low reset
//  IR         in   IR_W       instruction register contents (valid from DECODE onward)
//  ALU_Zero   in   1          ALU result == 0
//  Step       in   1          single-step pulse (used only with CU_SINGLE_STEP_EN)
//  PC_CLR     out  1          clear PC
//  PC_LD      out  1          load PC from PC_TARGET
//  PC_IC      out  1          increment PC
//  PC_TARGET  out  D_ADDR_W   branch/jump target
//  IR_LD      out  1          load IR from instruction memory
//  D_ADDR     out  D_ADDR_W   data-memory address
//  D_WR       out  1          data-memory write enable
//  RF_S       out  1          RF write-mux select: 1 = memory data, 0 = ALU
//  RF_W_EN    out  1          RF write enable
//  RF_A_ADDR  out  RF_ADDR_W  RF A-side read address
//  RF_B_ADDR  out  RF_ADDR_W  RF B-side read address
//  RF_W_ADDR  out  RF_ADDR_W  RF write address
//  ALU_S      out  ALU_S_W    ALU function select
//  Halted     out  1          CPU is in HALT
//  Instr_Count out CNT_W      retired-instruction count
// BEHAVIOUR
//  Moore outputs: decoded combinationally from the registered state and IR fields. Any output not listed for a state is 0.
//  Reset low (any time, including mid-instruction): state goes to INIT asynchronously and Instr_Count goes to 0.
//   - In INIT: PC_CLR=1; every other output is 0.
//  Opcodes:
//   - 0 NOOP
//   - 1 LOAD  addr=IR[11:4]  dst=IR[3:0]
//   - 2 STORE src=IR[11:8]   addr=IR[7:0]
//   - 3..C ADD,SUB,AND,OR,XOR,NAND,SHL,SHR,ROL,ROR: A=IR[11:8], B=IR[7:4], W=IR[3:0]; ALU_S = opcode-2 (ADD=1 .. ROR=0xA)
//   - D BZ    reg=IR[11:8]   tgt=IR[7:0]
//   - E JMP   tgt=IR[7:0]
//   - F HALT
//  Field slices scale with the parameters: reg fields are RF_ADDR_W bits and addr/tgt fields are D_ADDR_W bits, packed from the LSB.
//  States and transitions:
//   - INIT -> FETCH.
//   - FETCH: IR_LD=1 -> DECODE.
//   - DECODE: PC_IC=1; dispatches on opcode. NOOP -> FETCH; LOAD -> LOAD_A; STORE -> STORE; ALU ops -> EXEC; BZ/JMP -> BRANCH; HALT -> HALT.
//   - LOAD_A: D_ADDR, RF_S=1, RF_W_ADDR -> LOAD_B.
//   - LOAD_B: same as LOAD_A plus RF_W_EN=1 -> FETCH.
//   - STORE: D_ADDR=addr, RF_A_ADDR=src, D_WR=1 -> FETCH.
//   - EXEC: RF_A/B/W_ADDR, ALU_S, RF_W_EN=1, RF_S=0 -> FETCH.
//   - BRANCH: PC_TARGET=tgt; RF_A_ADDR=reg; ALU_S=0 (pass A). PC_LD=1 for JMP, or for BZ when ALU_Zero=1 -> FETCH.
//   - HALT: Halted=1; stays in HALT until reset.
//  PC_LD and PC_IC are never both 1 in the same cycle.
//  Latency: NOOP 2 cycles; LOAD 4; STORE/ALU/BZ/JMP 3.
//  Instr_Count increments by 1 on the last cycle of every instruction, including NOOP and the DECODE of HALT. It wraps modulo 2^CNT_W.
// CONFIGURATION
//  CU_SINGLE_STEP_EN defined: FETCH asserts IR_LD and advances only in a cycle where Step=1; otherwise it holds with all outputs 0.
//  CU_SINGLE_STEP_EN undefined: the Step input is ignored and FETCH always advances.
// STRUCTURE
//  Package cpu_pkg holds the opcode enum, the FSM state enum (typedef enum logic [3:0]) and the ALU_S constants.
//  Sub-module cu_decoder: combinational IR field extraction and opcode-class flags (is_alu, is_branch, ...).
// TESTING
//  Release Reset: 1 cycle with PC_CLR=1, then IR_LD=1, then PC_IC=1.
//  LOAD IR=0x1425 -> LOAD_A: D_ADDR=0x42, RF_S=1, RF_W_ADDR=5; LOAD_B: RF_W_EN=1; 4 cycles; Instr_Count +1.
//  ADD IR=0x3123 -> EXEC: A=1, B=2, W=3, ALU_S=1, RF_W_EN=1.
//  BZ IR=0xD7A0 with ALU_Zero=1 -> PC_LD=1, PC_TARGET=0xA0. Same IR with ALU_Zero=0 -> PC_LD=0.
//  HALT IR=0xF000 -> Halted=1 held for 20 cycles. Reset pulsed mid-LOAD_A -> INIT with Instr_Count=0.
//  With CU_SINGLE_STEP_EN: Step held at 0 -> stays in FETCH; a 1-cycle Step pulse -> exactly one instruction executes.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the CPU control path: opcodes, control-FSM states, ALU selects.
// Latency: none (types and constants only).
// Backpressure: none.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'h0,
        OP_LOAD  = 4'h1,
        OP_STORE = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_AND   = 4'h5,
        OP_OR    = 4'h6,
        OP_XOR   = 4'h7,
        OP_NAND  = 4'h8,
        OP_SHL   = 4'h9,
        OP_SHR   = 4'hA,
        OP_ROL   = 4'hB,
        OP_ROR   = 4'hC,
        OP_BZ    = 4'hD,
        OP_JMP   = 4'hE,
        OP_HALT  = 4'hF
    } opcode_t;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_LOAD_A = 4'd3,
        ST_LOAD_B = 4'd4,
        ST_STORE  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_BRANCH = 4'd7,
        ST_HALT   = 4'd8
    } state_t;

    // ALU select codes: PASS_A forwards the A operand (used for the BZ zero test),
    // the arithmetic/logic ops follow opcode order starting at ADD.
    localparam logic [3:0] ALU_PASS_A = 4'h0;
    localparam logic [3:0] ALU_ADD    = 4'h1;

endpackage

// File: rtl/cu_decoder.sv
// Instruction field extraction and opcode-class flags for the control FSM.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow IR directly.
module cu_decoder
    import cpu_pkg::*;
#(
    parameter int IR_W      = 16,
    parameter int D_ADDR_W  = 8,
    parameter int RF_ADDR_W = 4,
    parameter int ALU_S_W   = 4
) (
    input  logic [IR_W-1:0]      ir,
    output logic [RF_ADDR_W-1:0] rf_lo,
    output logic [RF_ADDR_W-1:0] rf_mid,
    output logic [RF_ADDR_W-1:0] rf_hi,
    output logic [RF_ADDR_W-1:0] rf_reg,
    output logic [D_ADDR_W-1:0]  addr_lo,
    output logic [D_ADDR_W-1:0]  addr_hi,
    output logic [ALU_S_W-1:0]   alu_sel,
    output logic                 is_noop,
    output logic                 is_load,
    output logic                 is_store,
    output logic                 is_alu,
    output logic                 is_bz,
    output logic                 is_jmp,
    output logic                 is_branch,
    output logic                 is_halt
);

    logic [3:0] opcode;
    logic [3:0] alu_code;

    assign opcode = ir[IR_W-1 -: 4];

    // Fields are packed from the LSB: the low register field is the write
    // destination, a data address sits either at the bottom (STORE/BZ/JMP)
    // or just above the destination register (LOAD).
    assign rf_lo   = ir[0 +: RF_ADDR_W];
    assign rf_mid  = ir[RF_ADDR_W +: RF_ADDR_W];
    assign rf_hi   = ir[2*RF_ADDR_W +: RF_ADDR_W];
    assign rf_reg  = ir[D_ADDR_W +: RF_ADDR_W];
    assign addr_lo = ir[0 +: D_ADDR_W];
    assign addr_hi = ir[RF_ADDR_W +: D_ADDR_W];

    // ALU ops are contiguous in the opcode map, so the select is an offset.
    assign alu_code = opcode - OP_ADD + ALU_ADD;
    assign alu_sel  = ALU_S_W'(alu_code);

    // Opcode class flags used by the FSM dispatch and retire logic.
    always_comb begin
        is_noop   = (opcode == OP_NOOP);
        is_load   = (opcode == OP_LOAD);
        is_store  = (opcode == OP_STORE);
        is_alu    = (opcode >= OP_ADD) && (opcode <= OP_ROR);
        is_bz     = (opcode == OP_BZ);
        is_jmp    = (opcode == OP_JMP);
        is_branch = is_bz || is_jmp;
        is_halt   = (opcode == OP_HALT);
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute control FSM with branch, sticky halt and retire counter.
// Latency: NOOP 2 cycles, LOAD 4, STORE/ALU/BZ/JMP 3; Moore outputs from registered state and IR.
// Backpressure: CU_SINGLE_STEP_EN makes FETCH wait for Step; without it Step is ignored.
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int IR_W      = 16,
    parameter int D_ADDR_W  = 8,
    parameter int RF_ADDR_W = 4,
    parameter int ALU_S_W   = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [IR_W-1:0]      IR,
    input  logic                 ALU_Zero,
    input  logic                 Step,
    output logic                 PC_CLR,
    output logic                 PC_LD,
    output logic                 PC_IC,
    output logic [D_ADDR_W-1:0]  PC_TARGET,
    output logic                 IR_LD,
    output logic [D_ADDR_W-1:0]  D_ADDR,
    output logic                 D_WR,
    output logic                 RF_S,
    output logic                 RF_W_EN,
    output logic [RF_ADDR_W-1:0] RF_A_ADDR,
    output logic [RF_ADDR_W-1:0] RF_B_ADDR,
    output logic [RF_ADDR_W-1:0] RF_W_ADDR,
    output logic [ALU_S_W-1:0]   ALU_S,
    output logic                 Halted,
    output logic [CNT_W-1:0]     Instr_Count
);

    state_t state;
    state_t state_nxt;

    logic [RF_ADDR_W-1:0] rf_lo;
    logic [RF_ADDR_W-1:0] rf_mid;
    logic [RF_ADDR_W-1:0] rf_hi;
    logic [RF_ADDR_W-1:0] rf_reg;
    logic [D_ADDR_W-1:0]  addr_lo;
    logic [D_ADDR_W-1:0]  addr_hi;
    logic [ALU_S_W-1:0]   alu_sel;
    logic                 is_noop;
    logic                 is_load;
    logic                 is_store;
    logic                 is_alu;
    logic                 is_bz;
    logic                 is_jmp;
    logic                 is_branch;
    logic                 is_halt;
    logic                 fetch_go;
    logic                 retire;

    cu_decoder #(
        .IR_W      (IR_W),
        .D_ADDR_W  (D_ADDR_W),
        .RF_ADDR_W (RF_ADDR_W),
        .ALU_S_W   (ALU_S_W)
    ) u_dec (
        .ir        (IR),
        .rf_lo     (rf_lo),
        .rf_mid    (rf_mid),
        .rf_hi     (rf_hi),
        .rf_reg    (rf_reg),
        .addr_lo   (addr_lo),
        .addr_hi   (addr_hi),
        .alu_sel   (alu_sel),
        .is_noop   (is_noop),
        .is_load   (is_load),
        .is_store  (is_store),
        .is_alu    (is_alu),
        .is_bz     (is_bz),
        .is_jmp    (is_jmp),
        .is_branch (is_branch),
        .is_halt   (is_halt)
    );

`ifdef CU_SINGLE_STEP_EN
    assign fetch_go = Step;
`else
    logic unused_step;
    assign unused_step = Step;
    assign fetch_go    = 1'b1;
`endif

    // State register; reset drops straight to INIT even mid-instruction.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: DECODE dispatches on opcode class, HALT is sticky.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:   state_nxt = ST_FETCH;
            ST_FETCH:  state_nxt = fetch_go ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (is_load)        state_nxt = ST_LOAD_A;
                else if (is_store)  state_nxt = ST_STORE;
                else if (is_alu)    state_nxt = ST_EXEC;
                else if (is_branch) state_nxt = ST_BRANCH;
                else if (is_halt)   state_nxt = ST_HALT;
                else                state_nxt = ST_FETCH;
            end
            ST_LOAD_A: state_nxt = ST_LOAD_B;
            ST_LOAD_B: state_nxt = ST_FETCH;
            ST_STORE:  state_nxt = ST_FETCH;
            ST_EXEC:   state_nxt = ST_FETCH;
            ST_BRANCH: state_nxt = ST_FETCH;
            ST_HALT:   state_nxt = ST_HALT;
            default:   state_nxt = ST_INIT;
        endcase
    end

    // Moore output decode; anything not driven for a state stays 0.
    always_comb begin
        PC_CLR    = 1'b0;
        PC_LD     = 1'b0;
        PC_IC     = 1'b0;
        PC_TARGET = '0;
        IR_LD     = 1'b0;
        D_ADDR    = '0;
        D_WR      = 1'b0;
        RF_S      = 1'b0;
        RF_W_EN   = 1'b0;
        RF_A_ADDR = '0;
        RF_B_ADDR = '0;
        RF_W_ADDR = '0;
        ALU_S     = '0;
        Halted    = 1'b0;
        case (state)
            ST_INIT:   PC_CLR = 1'b1;
            ST_FETCH:  IR_LD  = fetch_go;
            ST_DECODE: PC_IC  = 1'b1;
            ST_LOAD_A, ST_LOAD_B: begin
                // Address held for both cycles so memory data is stable at the write.
                D_ADDR    = addr_hi;
                RF_S      = 1'b1;
                RF_W_ADDR = rf_lo;
                RF_W_EN   = (state == ST_LOAD_B);
            end
            ST_STORE: begin
                D_ADDR    = addr_lo;
                RF_A_ADDR = rf_reg;
                D_WR      = 1'b1;
            end
            ST_EXEC: begin
                RF_A_ADDR = rf_hi;
                RF_B_ADDR = rf_mid;
                RF_W_ADDR = rf_lo;
                ALU_S     = alu_sel;
                RF_W_EN   = 1'b1;
            end
            ST_BRANCH: begin
                // ALU passes the tested register through so ALU_Zero reflects it.
                PC_TARGET = addr_lo;
                RF_A_ADDR = rf_reg;
                ALU_S     = ALU_S_W'(ALU_PASS_A);
                PC_LD     = is_jmp || (is_bz && ALU_Zero);
            end
            ST_HALT:   Halted = 1'b1;
            default:   ;
        endcase
    end

    // Last cycle of each instruction; NOOP and HALT finish in DECODE.
    assign retire = ((state == ST_DECODE) && (is_noop || is_halt)) ||
                    (state == ST_LOAD_B) || (state == ST_STORE) ||
                    (state == ST_EXEC)   || (state == ST_BRANCH);

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Instr_Count <= '0;
        end else if (retire) begin
            Instr_Count <= Instr_Count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: directed scenarios plus random instruction stream.
// Expectations come from a per-instruction transaction model (latency, PC/mem/RF events).
// Works with or without CU_SINGLE_STEP_EN; Step is held high outside the stepping scenario.
module tb_cpu_control_fsm;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] IR;
    logic        ALU_Zero;
    logic        Step;
    logic        PC_CLR, PC_LD, PC_IC, IR_LD, D_WR, RF_S, RF_W_EN, Halted;
    logic [7:0]  PC_TARGET, D_ADDR;
    logic [3:0]  RF_A_ADDR, RF_B_ADDR, RF_W_ADDR, ALU_S;
    logic [15:0] Instr_Count;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] cnt_model;

    cpu_control_fsm dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .IR          (IR),
        .ALU_Zero    (ALU_Zero),
        .Step        (Step),
        .PC_CLR      (PC_CLR),
        .PC_LD       (PC_LD),
        .PC_IC       (PC_IC),
        .PC_TARGET   (PC_TARGET),
        .IR_LD       (IR_LD),
        .D_ADDR      (D_ADDR),
        .D_WR        (D_WR),
        .RF_S        (RF_S),
        .RF_W_EN     (RF_W_EN),
        .RF_A_ADDR   (RF_A_ADDR),
        .RF_B_ADDR   (RF_B_ADDR),
        .RF_W_ADDR   (RF_W_ADDR),
        .ALU_S       (ALU_S),
        .Halted      (Halted),
        .Instr_Count (Instr_Count)
    );

    always #5 Clock = ~Clock;

    // 1-bit controls: {PC_CLR, PC_LD, PC_IC, IR_LD, D_WR, RF_S, RF_W_EN, Halted}
    function automatic logic [7:0] ctl();
        return {PC_CLR, PC_LD, PC_IC, IR_LD, D_WR, RF_S, RF_W_EN, Halted};
    endfunction

    function automatic logic [31:0] vec();
        return {PC_TARGET, D_ADDR, RF_A_ADDR, RF_B_ADDR, RF_W_ADDR, ALU_S};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after the negedge of a FETCH cycle; runs one instruction and
    // returns just after the negedge of the following FETCH cycle.
    task automatic run_instr(input logic [15:0] instr, input logic zero, input string tag);
        int         op, cyc, n_ic, n_ld, n_wr, n_rfw, n_bad;
        int         exp_lat, exp_ld, exp_wr, exp_rfw;
        logic [7:0] w_daddr, s_tgt;
        logic [3:0] w_a, w_b, w_w, w_alu, s_a, s_alu;
        logic       w_rfs;
        op = int'(instr >> 12);
        IR = instr;
        ALU_Zero = zero;
        cyc = 1; n_ic = 0; n_ld = 0; n_wr = 0; n_rfw = 0; n_bad = 0;
        w_daddr = '0; w_a = '0; w_b = '0; w_w = '0; w_alu = '0; w_rfs = 1'b0;
        s_tgt = '0; s_a = '0; s_alu = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clock);
            if (IR_LD) break;
            cyc++;
            if (PC_IC) n_ic++;
            if (PC_LD) n_ld++;
            if ((PC_LD && PC_IC) || PC_CLR || Halted) n_bad++;
            if (cyc == 3) begin
                s_tgt = PC_TARGET; s_a = RF_A_ADDR; s_alu = ALU_S;
            end
            if (D_WR) begin
                n_wr++; w_daddr = D_ADDR; w_a = RF_A_ADDR;
            end
            if (RF_W_EN) begin
                n_rfw++; w_daddr = D_ADDR; w_a = RF_A_ADDR; w_b = RF_B_ADDR;
                w_w = RF_W_ADDR; w_alu = ALU_S; w_rfs = RF_S;
            end
        end
        // Transaction-level expectations straight from the instruction set.
        exp_lat = (op == 0) ? 2 : (op == 1) ? 4 : 3;
        exp_ld  = (op == 14 || (op == 13 && zero)) ? 1 : 0;
        exp_wr  = (op == 2) ? 1 : 0;
        exp_rfw = (op == 1 || (op >= 3 && op <= 12)) ? 1 : 0;
        cnt_model = cnt_model + 16'd1;
        check({tag, ".latency"}, cyc, exp_lat);
        check({tag, ".pc_ic"}, n_ic, 1);
        check({tag, ".pc_ld"}, n_ld, exp_ld);
        check({tag, ".d_wr"}, n_wr, exp_wr);
        check({tag, ".rf_w_en"}, n_rfw, exp_rfw);
        check({tag, ".illegal"}, n_bad, 0);
        check({tag, ".fetch"}, ctl(), 8'h10);
        check({tag, ".count"}, Instr_Count, cnt_model);
        if (op == 1) begin
            check({tag, ".ld_addr"}, w_daddr, (instr >> 4) & 16'hFF);
            check({tag, ".ld_dst"}, w_w, instr & 16'hF);
            check({tag, ".ld_rfs"}, w_rfs, 1);
        end
        if (op == 2) begin
            check({tag, ".st_addr"}, w_daddr, instr & 16'hFF);
            check({tag, ".st_src"}, w_a, (instr >> 8) & 16'hF);
        end
        if (op >= 3 && op <= 12) begin
            check({tag, ".alu_a"}, w_a, (instr >> 8) & 16'hF);
            check({tag, ".alu_b"}, w_b, (instr >> 4) & 16'hF);
            check({tag, ".alu_w"}, w_w, instr & 16'hF);
            check({tag, ".alu_s"}, w_alu, op - 2);
            check({tag, ".alu_rfs"}, w_rfs, 0);
        end
        if (op == 13 || op == 14) begin
            check({tag, ".br_tgt"}, s_tgt, instr & 16'hFF);
            check({tag, ".br_reg"}, s_a, (instr >> 8) & 16'hF);
            check({tag, ".br_alu"}, s_alu, 0);
        end
    endtask

    // Bring the DUT out of reset and leave it just after the first FETCH negedge.
    task automatic release_reset();
        @(posedge Clock);
        #2 Reset = 1'b1;
        @(negedge Clock);
        check("init.ctl", ctl(), 8'h80);
        check("init.vec", vec(), 0);
        @(negedge Clock);
        check("first_fetch.ctl", ctl(), 8'h10);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n_ic, n_ir;
        logic [15:0] instr;
        logic [3:0]  op;
        Reset = 1'b0; IR = '0; ALU_Zero = 1'b0; Step = 1'b1; cnt_model = '0;

        repeat (2) @(negedge Clock);
        check("reset.ctl", ctl(), 8'h80);
        check("reset.vec", vec(), 0);
        check("reset.count", Instr_Count, 0);
        release_reset();

        run_instr(16'h0000, 1'b0, "noop");
        run_instr(16'h1425, 1'b0, "load");
        run_instr(16'h3123, 1'b0, "add");
        run_instr(16'hD7A0, 1'b1, "bz_taken");
        run_instr(16'hD7A0, 1'b0, "bz_not");
        run_instr(16'hE05C, 1'b0, "jmp");
        run_instr(16'h29F3, 1'b1, "store");
        run_instr(16'hCFED, 1'b1, "ror");

        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 14));
            instr = {op, 12'($urandom)};
            run_instr(instr, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

`ifdef CU_SINGLE_STEP_EN
        Step = 1'b0;
        IR = 16'h0000;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clock);
            if (ctl() == 8'h00) n++;
        end
        check("step.hold", n, 5);
        @(posedge Clock);
        #1 Step = 1'b1;
        @(negedge Clock);
        check("step.fetch", ctl(), 8'h10);
        @(posedge Clock);
        #1 Step = 1'b0;
        n_ic = 0; n_ir = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clock);
            if (PC_IC) n_ic++;
            if (IR_LD) n_ir++;
        end
        cnt_model = cnt_model + 16'd1;
        check("step.one_decode", n_ic, 1);
        check("step.no_refetch", n_ir, 0);
        check("step.count", Instr_Count, cnt_model);
        Step = 1'b1;
`endif

        IR = 16'hF000;
        @(negedge Clock);
        check("halt.decode", ctl(), 8'h20);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clock);
            if (ctl() == 8'h01 && vec() == 0) n++;
        end
        cnt_model = cnt_model + 16'd1;
        check("halt.held", n, 20);
        check("halt.count", Instr_Count, cnt_model);

        Reset = 1'b0;
        #1;
        cnt_model = '0;
        check("halt_reset.ctl", ctl(), 8'h80);
        check("halt_reset.count", Instr_Count, 0);
        release_reset();
        run_instr(16'h0000, 1'b0, "pre_abort_noop");

        IR = 16'h1425;
        @(negedge Clock);
        @(negedge Clock);
        check("abort.load_a_ctl", ctl(), 8'h04);
        check("abort.load_a_vec", vec(), 32'h0042_0050);
        #1 Reset = 1'b0;
        #1;
        cnt_model = '0;
        check("abort.ctl", ctl(), 8'h80);
        check("abort.vec", vec(), 0);
        check("abort.count", Instr_Count, 0);
        release_reset();
        run_instr(16'h0000, 1'b0, "post_abort_noop");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
